// File: rtl/byte_mem_responder.sv
// byte_mem_responder
// Memory-side responder for the load/store path. Each word-aligned 32-bit
// request is served as four sequential byte accesses to an internal
// byte-wide backing store (little-endian). Misaligned or out-of-range
// requests are rejected with a fault response and never touch the store.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle (IDLE and not in reset)
//   addr         byte address of the word
//   write_enable 1 = write, 0 = read
//   write_data   word to store
//   resp_valid   one-cycle completion pulse
//   read_data    word read; 0 on faulting responses; otherwise held
//   fault        qualifies resp_valid: request rejected
module byte_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        fault
);

    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [7:0]            mem [DEPTH];

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [WIDX_W-1:0]     word_idx_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [1:0]            beat_q;
    logic                  pad_q;
    logic [23:0]           rd_buf_q;
    logic [7:0]            mem_q;

    logic                  accept_c;
    logic                  req_fault_c;
    logic                  issue_c;
    logic [31:0]           addr_hi_c;
    logic [ADDR_WIDTH-1:0] byte_addr_c;
    logic [7:0]            wr_byte_c;

    // Request qualification; ready must drop during the reset cycle itself
    assign req_ready   = (state_q == IDLE) && !rst;
    assign accept_c    = req_valid && req_ready;
    assign addr_hi_c   = addr >> ADDR_WIDTH;
    assign req_fault_c = (addr[1:0] != 2'b00) || (addr_hi_c != 32'd0);

    // Beat addressing; gating on rst stops remaining writes at once
    assign issue_c     = (state_q == BEAT) && !pad_q && !rst;
    assign byte_addr_c = {word_idx_q, beat_q};
    assign wr_byte_c   = 8'(wdata_q >> {beat_q, 3'b000});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = req_fault_c ? DONE : BEAT;
                end
            end
            BEAT: begin
                if (pad_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, beat sequencing and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            beat_q     <= 2'd0;
            pad_q      <= 1'b0;
            rd_buf_q   <= 24'd0;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            read_data  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        word_idx_q <= addr[ADDR_WIDTH-1:2];
                        we_q       <= write_enable;
                        wdata_q    <= write_data;
                        beat_q     <= 2'd0;
                        pad_q      <= 1'b0;
                        if (req_fault_c) begin
                            resp_valid <= 1'b1;
                            fault      <= 1'b1;
                            read_data  <= 32'd0;
                        end
                    end
                end
                BEAT: begin
                    if (!pad_q) begin
                        // mem_q holds the byte issued on the previous beat
                        case (beat_q)
                            2'd1:    rd_buf_q[7:0]   <= mem_q;
                            2'd2:    rd_buf_q[15:8]  <= mem_q;
                            2'd3:    rd_buf_q[23:16] <= mem_q;
                            default: ;
                        endcase
                        if (beat_q == 2'd3) begin
                            pad_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end else begin
                        // Byte 3 capture (reads) or equal-latency pad (writes)
                        resp_valid <= 1'b1;
                        if (!we_q) begin
                            read_data <= {mem_q, rd_buf_q};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-wide backing store with registered read; contents not reset
    always_ff @(posedge clk) begin
        if (issue_c) begin
            if (we_q) begin
                mem[byte_addr_c] <= wr_byte_c;
            end
            mem_q <= mem[byte_addr_c];
        end
    end

endmodule

// File: tb/tb_byte_mem_responder.sv
// tb_byte_mem_responder
// Directed testbench for byte_mem_responder: requests push expected
// responses (fault, data, due cycle) into a scoreboard queue; responses
// pop and compare. Backdoor reads inspect the backing store.
module tb_byte_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        logic        chk_data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    byte_mem_responder #(.ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .resp_valid   (resp_valid),
        .read_data    (read_data),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: cycle k lies between posedge k and posedge k+1
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd(input logic [11:0] a, input logic [7:0] e);
        chk("backdoor", 32'(dut.mem[a]), 32'(e));
    endtask

    // Compare the current response against the scoreboard head
    task automatic check_resp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            chk("fault", 32'(fault), 32'(e.fault));
            if (e.chk_data) chk("read_data", read_data, e.data);
            chk("latency", 32'(cyc), 32'(e.due));
        end
    endtask

    // Wait (bounded) for the next response, starting at the current negedge
    task automatic wait_resp();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid === 1'b1) begin
                check_resp();
                got = 1'b1;
                break;
            end
            chk("fault_without_resp", 32'(fault), 32'd0);
            @(negedge clk);
        end
        if (!got) chk("resp_timeout", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    // Issue one request; returns at the negedge of the cycle after accept
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic ef, input logic [31:0] ed, input logic cd,
                          input int lat, input bit push);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid    = 1'b1;
        addr         = a;
        write_enable = w;
        write_data   = wd;
        for (int k = 0; k < 40; k++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'(ok), 32'd1);
        if (push) begin
            e.fault    = ef;
            e.data     = ed;
            e.chk_data = cd;
            e.due      = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    int acc1;
    int acc2;

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        addr         = 32'd0;
        write_enable = 1'b0;
        write_data   = 32'd0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        chk("resp_valid_reset", 32'(resp_valid), 32'd0);
        chk("fault_reset", 32'(fault), 32'd0);
        chk("read_data_reset", read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Write then read 0x010
        do_req(32'h010, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b1, 6, 1'b1);
        wait_resp();
        do_req(32'h010, 1'b0, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1, 6, 1'b1);
        wait_resp();
        bd(12'h010, 8'hEF);
        bd(12'h011, 8'hBE);
        bd(12'h012, 8'hAD);
        bd(12'h013, 8'hDE);

        // Misaligned write faults, store untouched
        do_req(32'h012, 1'b1, 32'h11223344, 1'b1, 32'd0, 1'b1, 1, 1'b1);
        wait_resp();
        bd(12'h010, 8'hEF);
        bd(12'h011, 8'hBE);
        bd(12'h012, 8'hAD);
        bd(12'h013, 8'hDE);
        chk("ready_after_fault", 32'(req_ready), 32'd1);

        // Out-of-range read faults; top word reads back normally
        do_req(32'h0000_1000, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 1, 1'b1);
        wait_resp();
        do_req(32'h0000_0FFC, 1'b1, 32'hCAFEF00D, 1'b0, 32'd0, 1'b1, 6, 1'b1);
        wait_resp();
        do_req(32'h0000_0FFC, 1'b0, 32'd0, 1'b0, 32'hCAFEF00D, 1'b1, 6, 1'b1);
        wait_resp();
        do_req(32'h8000_0010, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 1, 1'b1);
        wait_resp();

        // Good read, faulting read zeroes data, write holds it, good read restores
        do_req(32'h010, 1'b0, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1, 6, 1'b1);
        wait_resp();
        do_req(32'h011, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 1, 1'b1);
        wait_resp();
        chk("read_data_hold", read_data, 32'd0);
        do_req(32'h030, 1'b1, 32'h01234567, 1'b0, 32'd0, 1'b1, 6, 1'b1);
        wait_resp();
        chk("read_data_hold_after_write", read_data, 32'd0);
        bd(12'h030, 8'h67);
        bd(12'h033, 8'h01);
        do_req(32'h010, 1'b0, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1, 6, 1'b1);
        wait_resp();

        // Back-to-back reads with req_valid held throughout
        @(negedge clk);
        req_valid    = 1'b1;
        write_enable = 1'b0;
        addr         = 32'h010;
        acc1 = -1;
        for (int k = 0; k < 40; k++) begin
            if (req_ready === 1'b1) begin
                acc1 = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("b2b_first_accept", 32'(acc1 >= 0), 32'd1);
        sb.push_back('{fault: 1'b0, data: 32'hDEADBEEF, chk_data: 1'b1, due: acc1 + 6});
        sb.push_back('{fault: 1'b0, data: 32'h01234567, chk_data: 1'b1, due: acc1 + 13});
        @(negedge clk);
        addr = 32'h030;
        acc2 = -1;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid === 1'b1) check_resp();
            if (req_ready === 1'b1) begin
                acc2 = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd7);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp();

        // Reset mid-write after beats 0 and 1
        do_req(32'h020, 1'b1, 32'hAAAAAAAA, 1'b0, 32'd0, 1'b0, 6, 1'b1);
        wait_resp();
        do_req(32'h020, 1'b1, 32'h55667788, 1'b0, 32'd0, 1'b0, 6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("read_data_after_abort", read_data, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk("no_resp_after_abort", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        bd(12'h020, 8'h88);
        bd(12'h021, 8'h77);
        bd(12'h022, 8'hAA);
        bd(12'h023, 8'hAA);
        do_req(32'h020, 1'b0, 32'd0, 1'b0, 32'hAAAA7788, 1'b1, 6, 1'b1);
        wait_resp();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
